dot_scan_pwm: RTL and testbench

Parametrised successor to the fixed 8×8 two-colour dot-matrix scanner. It time-multiplexes a ROWS×COLS matrix with CH colour channels and adds four behaviours the old scanner lacks:
- double-buffered frame loading with a load/pending handshake;
- per-row PWM brightness;
- anti-ghost blanking;
- frame-synchronous blink.

It sits between the data/sequencing logic (which presents frame bitmaps) and the matrix pins, running directly off the system clock.

---
 rtl/dot_scan_pkg.sv | 34 +++
 rtl/dot_scan_pwm_timer.sv | 72 +++++++
 rtl/dot_scan_pwm.sv | 126 ++++++++++++
 tb/tb_dot_scan_pwm.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_scan_pkg.sv
// Shared constants, types and helpers for the dot-matrix PWM scanner.
package dot_scan_pkg;

  // Default parameter values: 8x8 two-colour panel, 1 MHz clock, 4 kHz row rate.
  localparam int unsigned DEF_ROWS     = 8;
  localparam int unsigned DEF_COLS     = 8;
  localparam int unsigned DEF_CH       = 2;
  localparam int unsigned DEF_DIV      = 250;
  localparam int unsigned DEF_BW       = 3;
  localparam int unsigned DEF_BLANK    = 2;
  localparam int unsigned DEF_BLINK_FR = 64;

  // Blink phase of the whole display.
  typedef enum logic {
    PH_VISIBLE = 1'b0,
    PH_DARK    = 1'b1
  } blink_phase_e;

  // Width that holds (brightness+1)*DIV without truncation.
  function automatic int unsigned on_len_w(input int unsigned div, input int unsigned bw);
    return $clog2(div) + bw + 1;
  endfunction

  localparam int unsigned DEF_ON_LEN_W = $clog2(DEF_DIV) + DEF_BW + 1;

  // Bit position of channel c, row r, column k inside a frame bitmap.
  function automatic int unsigned idx(input int unsigned c, input int unsigned r,
                                      input int unsigned k,
                                      input int unsigned rows = DEF_ROWS,
                                      input int unsigned cols = DEF_COLS);
    return (c * rows + r) * cols + k;
  endfunction

endpackage

// File: rtl/dot_scan_pwm_timer.sv
// Scan timing: tick within a row slot, row index, frame boundary and blink phase.
module scan_timer
  import dot_scan_pkg::*;
#(
  parameter int unsigned ROWS     = DEF_ROWS,
  parameter int unsigned DIV      = DEF_DIV,
  parameter int unsigned BLINK_FR = DEF_BLINK_FR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_blink_en,
  output logic [$clog2(DIV)-1:0]    o_tick,
  output logic [$clog2(ROWS)-1:0]   o_row_idx,
  output logic                      o_slot_start,
  output logic                      o_boundary,
  output blink_phase_e              o_phase
);

  localparam int unsigned TW = $clog2(DIV);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned FW = $clog2(BLINK_FR + 1);

  logic [TW-1:0] r_tick;
  logic [RW-1:0] r_row_idx;
  logic [FW-1:0] r_frame_cnt;
  blink_phase_e  r_phase;

  logic w_last_tick;
  logic w_last_row;

  assign w_last_tick = (r_tick == TW'(DIV - 1));
  assign w_last_row  = (r_row_idx == RW'(ROWS - 1));

  // Advance tick every clock; step to the next row (wrapping) after the last tick.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick    <= '0;
      r_row_idx <= '0;
    end else if (w_last_tick) begin
      r_tick    <= '0;
      r_row_idx <= w_last_row ? '0 : r_row_idx + RW'(1);
    end else begin
      r_tick    <= r_tick + TW'(1);
    end
  end

  // Count frames while blinking is enabled and flip the phase every BLINK_FR frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt <= '0;
      r_phase     <= PH_VISIBLE;
    end else if (!i_blink_en) begin
      r_frame_cnt <= '0;
      r_phase     <= PH_VISIBLE;
    end else if (o_boundary) begin
      if (r_frame_cnt == FW'(BLINK_FR - 1)) begin
        r_frame_cnt <= '0;
        r_phase     <= (r_phase == PH_DARK) ? PH_VISIBLE : PH_DARK;
      end else begin
        r_frame_cnt <= r_frame_cnt + FW'(1);
      end
    end
  end

  assign o_tick       = r_tick;
  assign o_row_idx    = r_row_idx;
  assign o_slot_start = (r_tick == '0);
  assign o_boundary   = w_last_tick && w_last_row;
  assign o_phase      = r_phase;

endmodule

// File: rtl/dot_scan_pwm.sv
// Dot-matrix scanner with double-buffered frames, per-row PWM, blanking and blink.
module dot_scan_pwm
  import dot_scan_pkg::*;
#(
  parameter int unsigned ROWS     = DEF_ROWS,
  parameter int unsigned COLS     = DEF_COLS,
  parameter int unsigned CH       = DEF_CH,
  parameter int unsigned DIV      = DEF_DIV,
  parameter int unsigned BW       = DEF_BW,
  parameter int unsigned BLANK    = DEF_BLANK,
  parameter int unsigned BLINK_FR = DEF_BLINK_FR
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ROWS*COLS*CH-1:0]   frame_data,
  input  logic                      load,
  input  logic [BW-1:0]             brightness,
  input  logic                      blink_en,
  output logic                      pending,
  output logic                      frame_start,
  output logic [ROWS-1:0]           row,
  output logic [CH*COLS-1:0]        col
);

  localparam int unsigned NB  = ROWS * COLS * CH;
  localparam int unsigned TW  = $clog2(DIV);
  localparam int unsigned RW  = $clog2(ROWS);
  localparam int unsigned OLW = on_len_w(DIV, BW);

  logic [TW-1:0]      w_tick;
  logic [RW-1:0]      w_row_idx;
  logic               w_slot_start;
  logic               w_boundary;
  blink_phase_e       w_phase;

  logic [NB-1:0]      r_active;
  logic [NB-1:0]      r_shadow;
  logic               r_pending;
  logic [BW-1:0]      r_bright;
  logic [ROWS-1:0]    r_row;
  logic [CH*COLS-1:0] r_col;
  logic               r_frame_start;

  logic [BW-1:0]      w_bright;
  logic [OLW-1:0]     w_on_len;
  logic               w_in_window;
  logic               w_visible;
  logic [CH*COLS-1:0] w_row_bits;

  scan_timer #(
    .ROWS     (ROWS),
    .DIV      (DIV),
    .BLINK_FR (BLINK_FR)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_blink_en   (blink_en),
    .o_tick       (w_tick),
    .o_row_idx    (w_row_idx),
    .o_slot_start (w_slot_start),
    .o_boundary   (w_boundary),
    .o_phase      (w_phase)
  );

  // Frame load handshake: shadow fill, boundary swap, and boundary bypass.
  // NOTE: the frame buffers are reset so a freshly reset panel shows a blank frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else if (load && w_boundary) begin
      r_active  <= frame_data;
      r_pending <= 1'b0;
    end else if (load) begin
      r_shadow  <= frame_data;
      r_pending <= 1'b1;
    end else if (w_boundary && r_pending) begin
      r_active  <= r_shadow;
      r_pending <= 1'b0;
    end
  end

  // Hold the brightness seen at slot start for the rest of the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bright <= '0;
    end else if (w_slot_start) begin
      r_bright <= brightness;
    end
  end

  // At tick 0 the live input is the slot's level; afterwards the held copy is.
  assign w_bright    = w_slot_start ? brightness : r_bright;
  assign w_on_len    = ((OLW'(w_bright) + OLW'(1)) * OLW'(DIV)) >> BW;
  assign w_in_window = (OLW'(w_tick) >= OLW'(BLANK)) && (OLW'(w_tick) < w_on_len);
  assign w_visible   = !(blink_en && (w_phase == PH_DARK));

  // Gather the current row's bits of every channel from the active frame.
  // NOTE: defaulting the whole vector first keeps this purely combinational.
  always_comb begin
    w_row_bits = '0;
    for (int c = 0; c < CH; c++) begin
      w_row_bits[c*COLS +: COLS] = r_active[idx(c, int'(w_row_idx), 0, ROWS, COLS) +: COLS];
    end
  end

  // Register the pin drive one clock after the counter state it reflects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row         <= '1;
      r_col         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_row         <= ~(ROWS'(1) << w_row_idx);
      r_col         <= (w_in_window && w_visible) ? w_row_bits : '0;
      r_frame_start <= w_slot_start && (w_row_idx == '0);
    end
  end

  assign pending     = r_pending;
  assign frame_start = r_frame_start;
  assign row         = r_row;
  assign col         = r_col;

endmodule

// File: tb/tb_dot_scan_pwm.sv
// Directed bench for dot_scan_pwm with a cycle-level reference model and scoreboard.
module tb_dot_scan_pwm;

  localparam int ROWS     = 8;
  localparam int COLS     = 8;
  localparam int CH       = 2;
  localparam int DIV      = 16;
  localparam int BW       = 3;
  localparam int BLANK    = 2;
  localparam int BLINK_FR = 2;
  localparam int NB       = ROWS * COLS * CH;

  typedef struct packed {
    logic [ROWS-1:0]    row;
    logic [CH*COLS-1:0] col;
    logic               pend;
    logic               fs;
  } obs_t;

  logic               clk;
  logic               rst;
  logic [NB-1:0]      frame_data;
  logic               load;
  logic [BW-1:0]      brightness;
  logic               blink_en;
  logic               pending;
  logic               frame_start;
  logic [ROWS-1:0]    row;
  logic [CH*COLS-1:0] col;

  int n_checks = 0;
  int n_errors = 0;

  obs_t  q_exp[$];
  string q_tag[$];

  // Reference model state: m_s counts clocks since reset release.
  int            m_s;
  logic [NB-1:0] m_shown;
  logic [NB-1:0] m_shadow;
  bit            m_pend;
  int            m_bslot;
  int            m_bfr;

  dot_scan_pwm #(
    .ROWS (ROWS), .COLS (COLS), .CH (CH), .DIV (DIV),
    .BW (BW), .BLANK (BLANK), .BLINK_FR (BLINK_FR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_data  (frame_data),
    .load        (load),
    .brightness  (brightness),
    .blink_en    (blink_en),
    .pending     (pending),
    .frame_start (frame_start),
    .row         (row),
    .col         (col)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // kind 0: checkerboard, 1: all ones, 2: walking bit / 0F, 3: 3C / C3
  function automatic logic [NB-1:0] make_frame(input int kind);
    logic [NB-1:0] f;
    logic [7:0]    c0, c1;
    f = '0;
    for (int r = 0; r < ROWS; r++) begin
      case (kind)
        0:       begin c0 = (r % 2 == 0) ? 8'h55 : 8'hAA; c1 = ~c0; end
        1:       begin c0 = 8'hFF; c1 = 8'hFF; end
        2:       begin c0 = 8'h01 << r; c1 = 8'h0F; end
        default: begin c0 = 8'h3C; c1 = 8'hC3; end
      endcase
      f[(0 * ROWS + r) * COLS +: COLS] = c0;
      f[(1 * ROWS + r) * COLS +: COLS] = c1;
    end
    return f;
  endfunction

  function automatic logic [CH*COLS-1:0] row_bits(input logic [NB-1:0] f, input int r);
    logic [CH*COLS-1:0] b;
    b = '0;
    for (int c = 0; c < CH; c++) b[c*COLS +: COLS] = f[(c * ROWS + r) * COLS +: COLS];
    return b;
  endfunction

  task automatic model_reset();
    m_s      = 0;
    m_shown  = '0;
    m_shadow = '0;
    m_pend   = 1'b0;
    m_bslot  = 0;
    m_bfr    = 0;
  endtask

  task automatic check_front();
    obs_t  e;
    obs_t  g;
    string t;
    e = q_exp.pop_front();
    t = q_tag.pop_front();
    g = {row, col, pending, frame_start};
    n_checks++;
    assert (g === e) else begin
      n_errors++;
      $error("FAIL %s: got row=%h col=%h pend=%b fs=%b, want row=%h col=%h pend=%b fs=%b",
             t, g.row, g.col, g.pend, g.fs, e.row, e.col, e.pend, e.fs);
    end
  endtask

  // Literal expectation compared against the outputs as they stand now.
  task automatic spot(input string tag, input logic [ROWS-1:0] er,
                      input logic [CH*COLS-1:0] ec, input logic ep, input logic ef);
    obs_t e;
    e = {er, ec, ep, ef};
    q_exp.push_back(e);
    q_tag.push_back(tag);
    check_front();
  endtask

  // One clock: predict the registered outputs from the inputs now applied, then compare.
  task automatic cycle(input string tag);
    int   tick, r, b, on_len;
    bit   bnd, lit, dark;
    obs_t e;
    tick   = m_s % DIV;
    r      = (m_s / DIV) % ROWS;
    bnd    = (tick == DIV - 1) && (r == ROWS - 1);
    b      = (tick == 0) ? int'(brightness) : m_bslot;
    on_len = ((b + 1) * DIV) >> BW;
    dark   = blink_en && (((m_bfr / BLINK_FR) % 2) == 1);
    lit    = (tick >= BLANK) && (tick < on_len) && !dark;
    e.row  = ~(8'h01 << r);
    e.col  = lit ? row_bits(m_shown, r) : '0;
    e.fs   = (tick == 0) && (r == 0);
    m_bslot = b;
    if (load && bnd) begin
      m_shown = frame_data;
      m_pend  = 1'b0;
    end else if (load) begin
      m_shadow = frame_data;
      m_pend   = 1'b1;
    end else if (bnd && m_pend) begin
      m_shown = m_shadow;
      m_pend  = 1'b0;
    end
    if (!blink_en) m_bfr = 0;
    else if (bnd) m_bfr++;
    e.pend = m_pend;
    m_s++;
    q_exp.push_back(e);
    q_tag.push_back(tag);
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic run_through(input int last, input string tag);
    while (m_s <= last) cycle(tag);
  endtask

  initial begin
    rst        = 1'b0;
    frame_data = '0;
    load       = 1'b0;
    brightness = 3'd7;
    blink_en   = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    spot("reset_hold", 8'hFF, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    cycle("first");
    spot("first_fs", 8'hFE, 16'h0000, 1'b0, 1'b1);
    run_through(19, "scan0");

    frame_data = make_frame(0);
    load = 1'b1;
    cycle("load_cb");
    load = 1'b0;
    spot("pend_set", 8'hFD, 16'h0000, 1'b1, 1'b0);

    run_through(130, "swap_cb");
    spot("cb_row0", 8'hFE, 16'hAA55, 1'b0, 1'b0);
    run_through(128 + 53, "cb_scan");
    spot("cb_row3", 8'hF7, 16'h55AA, 1'b0, 1'b0);
    run_through(255, "cb_scan");
    spot("cb_row7_last", 8'h7F, 16'h55AA, 1'b0, 1'b0);

    brightness = 3'd0;
    run_through(258, "pwm0");
    spot("pwm0_dark", 8'hFE, 16'h0000, 1'b0, 1'b0);
    run_through(269, "pwm0");
    brightness = 3'd3;
    run_through(275, "pwm3");
    brightness = 3'd7;
    run_through(279, "pwm3");
    spot("pwm3_tick7", 8'hFD, 16'h55AA, 1'b0, 1'b0);
    run_through(280, "pwm3");
    spot("pwm3_tick8", 8'hFD, 16'h0000, 1'b0, 1'b0);

    run_through(399, "pre_a");
    frame_data = make_frame(1);
    load = 1'b1;
    cycle("load_a");
    load = 1'b0;
    run_through(410, "hold");
    spot("hold_old", 8'hFD, 16'h55AA, 1'b1, 1'b0);
    run_through(449, "hold");
    frame_data = make_frame(2);
    load = 1'b1;
    cycle("load_b");
    load = 1'b0;
    run_through(514, "swap_b");
    spot("latest_only", 8'hFE, 16'h0F01, 1'b0, 1'b0);

    run_through(638, "show_b");
    frame_data = make_frame(3);
    load = 1'b1;
    cycle("load_bnd");
    load = 1'b0;
    spot("bnd_nopend", 8'h7F, 16'h0F80, 1'b0, 1'b0);
    run_through(642, "show_c");
    spot("bnd_shown", 8'hFE, 16'hC33C, 1'b0, 1'b0);

    run_through(767, "show_c");
    blink_en = 1'b1;
    run_through(1026, "blink");
    spot("blink_dark", 8'hFE, 16'h0000, 1'b0, 1'b0);
    run_through(1282, "blink");
    spot("blink_vis", 8'hFE, 16'hC33C, 1'b0, 1'b0);
    run_through(1575, "blink");
    spot("blink_dark12", 8'hFB, 16'h0000, 1'b0, 1'b0);
    blink_en = 1'b0;
    cycle("blink_off");
    spot("blink_off_vis", 8'hFB, 16'hC33C, 1'b0, 1'b0);

    run_through(1589, "pre_d");
    frame_data = make_frame(1);
    load = 1'b1;
    cycle("load_d");
    load = 1'b0;
    run_through(1600, "pend_d");
    spot("pend_before_rst", 8'hEF, 16'h0000, 1'b1, 1'b0);

    #3;
    rst = 1'b0;
    #1;
    spot("rst_async", 8'hFF, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    spot("rst_held", 8'hFF, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    cycle("post_rst");
    spot("post_rst_fs", 8'hFE, 16'h0000, 1'b0, 1'b1);
    run_through(130, "discard");
    spot("discarded", 8'hFE, 16'h0000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
